// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer that lends one shared
// 32-bit combinational ALU to NREQ requesters. Each operation goes through
// accept (IDLE), execute (EXEC) and respond (RESP). An optional commit
// writes the architectural NZCV flag register on response handshake.
module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  input  logic [NREQ-1:0]   req_setf,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [1:0]        alu_op,
  input  logic [31:0]       alu_r,
  input  logic [3:0]        alu_f,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_r,
  output logic [3:0]        resp_f,
  output logic [3:0]        flags_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Requester count and last index at the widths the arbiter arithmetic uses.
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_t          state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  cur_id_r;
  logic            cur_setf_r;

  logic            grant_found_s;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW:0]    cand_s;
  logic [NREQ-1:0] grant_onehot_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_id_s    = cand_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept strobe: one-hot to the winner, only while waiting in IDLE.
  always_comb begin
    grant_onehot_s = '0;
    grant_onehot_s[grant_id_s] = 1'b1;
    if ((state_r == ST_IDLE) && grant_found_s) begin
      req_ready = grant_onehot_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operation sequencer: accept, execute, hold response until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      cur_id_r   <= '0;
      cur_setf_r <= 1'b0;
      alu_a      <= 32'h0000_0000;
      alu_b      <= 32'h0000_0000;
      alu_op     <= 2'b00;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_r     <= 32'h0000_0000;
      resp_f     <= 4'b0000;
      flags_q    <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            alu_a      <= req_a[grant_id_s*32 +: 32];
            alu_b      <= req_b[grant_id_s*32 +: 32];
            alu_op     <= req_op[grant_id_s*2 +: 2];
            cur_id_r   <= grant_id_s;
            cur_setf_r <= req_setf[grant_id_s];
            busy       <= 1'b1;
            state_r    <= ST_EXEC;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          resp_r     <= alu_r;
          resp_f     <= alu_f;
          resp_id    <= cur_id_r;
          resp_valid <= 1'b1;
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            if (cur_setf_r) begin
              flags_q <= resp_f;
            end else begin
              flags_q <= flags_q;
            end
            if (cur_id_r == LAST_ID) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= cur_id_r + IDW'(1);
            end
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r    <= ST_RESP;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed operations push expected
// responses; a monitor pops and compares on every response handshake.
module tb_alu_share_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = 4'b0000;
  logic [3:0]    req_ready;
  logic [127:0]  req_a = '0;
  logic [127:0]  req_b = '0;
  logic [7:0]    req_op = '0;
  logic [3:0]    req_setf = '0;
  logic [31:0]   alu_a, alu_b, alu_r;
  logic [1:0]    alu_op;
  logic [3:0]    alu_f;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_id;
  logic [31:0]   resp_r;
  logic [3:0]    resp_f;
  logic [3:0]    flags_q;
  logic          busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  alu_share_ctrl #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_setf(req_setf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_f(alu_f),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_r(resp_r), .resp_f(resp_f),
    .flags_q(flags_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter for grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU stand-in: add/sub/and/or; sub carry means borrow.
  logic [32:0] sum_s;
  always_comb begin
    sum_s = 33'd0;
    alu_f = 4'b0000;
    case (alu_op)
      2'b00: sum_s = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: sum_s = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: sum_s = {1'b0, alu_a & alu_b};
      default: sum_s = {1'b0, alu_a | alu_b};
    endcase
    alu_r = sum_s[31:0];
    alu_f[3] = alu_r[31];
    alu_f[2] = (alu_r == 32'd0);
    alu_f[1] = (alu_op[1] == 1'b0) ? sum_s[32] : 1'b0;
    if (alu_op == 2'b00)
      alu_f[0] = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
    else if (alu_op == 2'b01)
      alu_f[0] = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
    else
      alu_f[0] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_resp: got id=%0d r=%h, expected none", resp_id, resp_r);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_r", resp_r, e.r);
        chk("resp_f", 32'(resp_f), 32'(e.f));
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic sf);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*2 +: 2]  = op;
    req_setf[i]       = sf;
  endtask

  // Waits (bounded) for a grant and checks it is the expected requester.
  task automatic wait_grant(input int id);
    logic [3:0] oh;
    bit got;
    oh = 4'b0000;
    oh[id] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) got = 1'b1;
    end
    if (got) chk("grant", 32'(req_ready), 32'(oh));
    else chk("grant_timeout", 32'(req_ready), 32'(oh));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation from a single requester and push its expectation.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic sf,
                        input logic [31:0] er, input logic [3:0] ef);
    exp_t e;
    @(posedge clk); #1;
    set_req(id, a, b, op, sf);
    req_valid = 4'b0000;
    req_valid[id] = 1'b1;
    wait_grant(id);
    e.id = 2'(id); e.r = er; e.f = ef;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 4'b0000;
  endtask

  initial begin
    exp_t e;
    int prev;
    int vhigh;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single op: requester 2, 5-5 with flag commit; latency check.
    resp_ready = 1'b1;
    run_op(2, 32'd5, 32'd5, 2'b01, 1'b1, 32'd0, 4'b0100);
    @(negedge clk);
    chk("lat_exec_valid", 32'(resp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_flags", 32'(flags_q), 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    chk("single_flags", 32'(flags_q), 32'h4);
    chk("single_done", 32'(resp_valid), 32'd0);

    // Carry/zero without commit.
    run_op(3, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0, 32'd0, 4'b0110);
    wait_idle();
    chk("carry_flags_kept", 32'(flags_q), 32'h4);

    // Round-robin with all requesters continuously valid.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'h100, 2'b00, 1'b0);
    req_valid = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % 4);
      e.id = 2'(g % 4); e.r = 32'h101 + 32'(g % 4); e.f = 4'b0000;
      sb_q.push_back(e);
      if (g > 0) chk("rr_interval", 32'(cyc - prev), 32'd3);
      prev = cyc;
      @(posedge clk); #1;
      if (g == 4) req_valid = 4'b0000;
    end
    wait_idle();

    // Backpressure: OR result held for 5 stalled cycles.
    resp_ready = 1'b0;
    run_op(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11, 1'b1, 32'hFFFF_FFFF, 4'b1000);
    req_valid = 4'b1000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_r", resp_r, 32'hFFFF_FFFF);
      chk("bp_n", 32'(resp_f[3]), 32'd1);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("bp_complete", 32'(resp_valid), 32'd0);
    chk("bp_flags", 32'(flags_q), 32'h8);

    // Withdrawn request: requester 1 pulses valid during EXEC.
    @(posedge clk); #1;
    set_req(2, 32'hFF00_FF00, 32'h0FF0_0FF0, 2'b10, 1'b0);
    req_valid = 4'b0100;
    wait_grant(2);
    e.id = 2'd2; e.r = 32'h0F00_0F00; e.f = 4'b0000;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("wd_no_grant_exec", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    vhigh = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) vhigh++;
    end
    chk("wd_never_granted", 32'(vhigh), 32'd0);
    chk("wd_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("wd_flags", 32'(flags_q), 32'h8);

    // Reset in RESP with resp_ready low aborts the operation.
    resp_ready = 1'b0;
    run_op(3, 32'd1, 32'd2, 2'b00, 1'b1, 32'd3, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_resp_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("mr_resp_valid", 32'(resp_valid), 32'd0);
    chk("mr_flags", 32'(flags_q), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_resp_r", resp_r, 32'd0);
    chk("mr_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    vhigh = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) vhigh++;
    end
    chk("mr_no_resp", 32'(vhigh), 32'd0);

    // After reset the pointer restarts at requester 0; sub with borrow.
    @(posedge clk); #1;
    set_req(0, 32'd7, 32'd9, 2'b01, 1'b1);
    req_valid = 4'b1111;
    wait_grant(0);
    e.id = 2'd0; e.r = 32'hFFFF_FFFE; e.f = 4'b1010;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle();
    chk("post_rst_flags", 32'(flags_q), 32'hA);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
